// File: rtl/kbd_rtc_ctrl.sv
// Key-event controller for the RTC/date/chrono datapath: edge detection, view/edit FSM,
// field cursor, inc/dec with auto-repeat, commit/abort timeout and chrono run/clear.
module kbd_rtc_ctrl #(
   parameter int HOLD_CYC    = 50_000_000,
   parameter int REP_CYC     = 10_000_000,
   parameter int TIMEOUT_CYC = 1_000_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_a,
   input  logic       key_b,
   input  logic       key_c,
   input  logic       key_d,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   output logic [1:0] mode,
   output logic       edit,
   output logic [1:0] field,
   output logic       inc_p,
   output logic       dec_p,
   output logic       commit_p,
   output logic       abort_p,
   output logic       crono_run,
   output logic       crono_clr_p
);

   localparam int RMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [RW-1:0] HOLD_M1 = RW'(HOLD_CYC - 1);
   localparam logic [RW-1:0] REP_M1  = RW'(REP_CYC - 1);
   localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic {VIEW, EDIT} state_t;

   // Bit order doubles as priority: lowest set bit wins (D > A > B > C > up > down > left > right).
   logic [7:0] key_cur;
   logic [7:0] key_prev_q;
   logic [7:0] edge_w;
   logic [7:0] win;
   assign key_cur = {key_right, key_left, key_down, key_up, key_c, key_b, key_a, key_d};
   assign edge_w  = key_cur & ~key_prev_q;
   assign win     = edge_w & (~edge_w + 8'd1);

   state_t          state_q;
   logic [1:0]      mode_q;
   logic [1:0]      field_q;
   logic            run_q;
   logic            inc_q, dec_q, commit_q, abort_q, clr_q;
   logic            rep_act_q, rep_dn_q, rep_first_q;
   logic [RW-1:0]   rep_cnt_q;
   logic [TW-1:0]   idle_q;

   logic rep_held;
   logic rep_fire;
   logic timeout;
   assign rep_held = rep_dn_q ? key_down : key_up;
   assign rep_fire = (state_q == EDIT) && rep_act_q && (edge_w == 8'd0) && rep_held &&
                     (rep_cnt_q == (rep_first_q ? HOLD_M1 : REP_M1));
   assign timeout  = (state_q == EDIT) && (idle_q == TO_M1);

   always_ff @(posedge clk) begin
      if (reset) begin
         key_prev_q  <= '0;
         state_q     <= VIEW;
         mode_q      <= 2'd0;
         field_q     <= 2'd0;
         run_q       <= 1'b0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         commit_q    <= 1'b0;
         abort_q     <= 1'b0;
         clr_q       <= 1'b0;
         rep_act_q   <= 1'b0;
         rep_dn_q    <= 1'b0;
         rep_first_q <= 1'b0;
         rep_cnt_q   <= '0;
         idle_q      <= '0;
      end else begin
         key_prev_q <= key_cur;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         commit_q   <= 1'b0;
         abort_q    <= 1'b0;
         clr_q      <= 1'b0;
         case (state_q)
            VIEW: begin
               rep_act_q <= 1'b0;
               idle_q    <= '0;
               if (win[0]) begin
                  state_q <= EDIT;
                  field_q <= 2'd0;
               end else if (win[1]) begin
                  mode_q <= 2'd0;
               end else if (win[2]) begin
                  mode_q <= 2'd1;
               end else if (win[3]) begin
                  mode_q <= 2'd2;
               end else if (win[4] && mode_q == 2'd2) begin
                  run_q <= ~run_q;
               end else if (win[5] && mode_q == 2'd2) begin
                  clr_q <= 1'b1;
                  run_q <= 1'b0;
               end
            end
            EDIT: begin
               if (win[0]) begin
                  commit_q  <= 1'b1;
                  state_q   <= VIEW;
                  field_q   <= 2'd0;
                  rep_act_q <= 1'b0;
               end else if (win[4] || win[5]) begin
                  inc_q       <= win[4];
                  dec_q       <= win[5];
                  rep_act_q   <= 1'b1;
                  rep_dn_q    <= win[5];
                  rep_first_q <= 1'b1;
                  rep_cnt_q   <= '0;
                  idle_q      <= '0;
               end else if (win[6] || win[7]) begin
                  if (win[6])
                     field_q <= (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
                  else
                     field_q <= (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                  rep_act_q <= 1'b0;
                  idle_q    <= '0;
               end else begin
                  // A/B/C edges are not acted on here but still cancel auto-repeat.
                  if (edge_w != 8'd0 || !rep_held)
                     rep_act_q <= 1'b0;
                  if (rep_fire) begin
                     inc_q       <= ~rep_dn_q;
                     dec_q       <= rep_dn_q;
                     rep_cnt_q   <= '0;
                     rep_first_q <= 1'b0;
                     idle_q      <= '0;
                  end else begin
                     if (rep_act_q)
                        rep_cnt_q <= rep_cnt_q + RW'(1);
                     if (timeout) begin
                        abort_q   <= 1'b1;
                        state_q   <= VIEW;
                        field_q   <= 2'd0;
                        rep_act_q <= 1'b0;
                     end else begin
                        idle_q <= idle_q + TW'(1);
                     end
                  end
               end
            end
            default: state_q <= VIEW;
         endcase
      end
   end

   assign mode        = mode_q;
   assign edit        = (state_q == EDIT);
   assign field       = field_q;
   assign inc_p       = inc_q;
   assign dec_p       = dec_q;
   assign commit_p    = commit_q;
   assign abort_p     = abort_q;
   assign crono_run   = run_q;
   assign crono_clr_p = clr_q;

endmodule

// File: tb/tb_kbd_rtc_ctrl.sv
// Directed bench for kbd_rtc_ctrl with a per-cycle expected-output scoreboard.
module tb_kbd_rtc_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] keys = 8'd0;
   logic [1:0] mode, field;
   logic       edit, inc_p, dec_p, commit_p, abort_p, crono_run, crono_clr_p;

   always #5 clk = ~clk;

   kbd_rtc_ctrl #(.HOLD_CYC(4), .REP_CYC(2), .TIMEOUT_CYC(20)) dut (
      .clk(clk), .reset(reset),
      .key_a(keys[1]), .key_b(keys[2]), .key_c(keys[3]), .key_d(keys[0]),
      .key_up(keys[4]), .key_down(keys[5]), .key_left(keys[6]), .key_right(keys[7]),
      .mode(mode), .edit(edit), .field(field),
      .inc_p(inc_p), .dec_p(dec_p), .commit_p(commit_p), .abort_p(abort_p),
      .crono_run(crono_run), .crono_clr_p(crono_clr_p)
   );

   localparam logic [7:0] KD = 8'h01, KA = 8'h02, KB = 8'h04, KC = 8'h08;
   localparam logic [7:0] KU = 8'h10, KN = 8'h20, KL = 8'h40, KR = 8'h80;
   // Pulse mask order: {inc, dec, commit, abort, clr}
   localparam logic [4:0] P0 = 5'b00000, PI = 5'b10000, PD = 5'b01000;
   localparam logic [4:0] PC = 5'b00100, PA = 5'b00010, PL = 5'b00001;

   logic [1:0] e_mode = 2'd0;
   logic       e_edit = 1'b0;
   logic [1:0] e_field = 2'd0;
   logic       e_run = 1'b0;

   logic [10:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          failures = 0;
   int          stepno = 0;

   task automatic step(input string tag, input logic [7:0] k, input logic [4:0] pul);
      logic [10:0] exp_v;
      logic [10:0] got;
      string       t;
      @(negedge clk);
      keys = k;
      exp_q.push_back({e_mode, e_edit, e_field, e_run, pul});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      got   = {mode, edit, field, crono_run, inc_p, dec_p, commit_p, abort_p, crono_clr_p};
      checks++;
      assert (got === exp_v) else begin
         failures++;
         $display("FAIL %s step=%0d observed=%h expected=%h", t, stepno, got, exp_v);
         $error("check %s", t);
      end
      $display("step %0d %s keys=%h out=%h", stepno, t, k, got);
      stepno++;
   endtask

   initial begin
      // reset values
      reset = 1'b1;
      step("rst0", 8'd0, P0);
      step("rst1", 8'd0, P0);
      reset = 1'b0;
      step("idle", 8'd0, P0);

      // B selects date mode, release has no effect
      e_mode = 2'd1;
      for (int i = 0; i < 3; i++) step("b_hold", KB, P0);
      step("b_rel", 8'd0, P0);

      // enter EDIT, walk the cursor
      e_edit = 1'b1; e_field = 2'd0;
      step("d_enter", KD, P0);
      step("rel", 8'd0, P0);
      e_field = 2'd1; step("right1", KR, P0); step("rel", 8'd0, P0);
      e_field = 2'd2; step("right2", KR, P0); step("rel", 8'd0, P0);
      e_field = 2'd0; step("right3", KR, P0); step("rel", 8'd0, P0);
      e_field = 2'd2; step("left1", KL, P0);  step("rel", 8'd0, P0);
      step("down", KN, PD);
      step("rel", 8'd0, P0);

      // held up: pulses at 0,4,6,8,10
      for (int j = 0; j < 12; j++)
         step("up_hold", KU, (j == 0 || j == 4 || j == 6 || j == 8 || j == 10) ? PI : P0);
      // last accepted event at j=10; timeout after 20 idle edges (j=30)
      for (int j = 12; j < 30; j++) step("up_rel", 8'd0, P0);
      e_edit = 1'b0; e_field = 2'd0;
      step("timeout_a", 8'd0, PA);
      step("after_to", 8'd0, P0);

      // fresh EDIT, 20 idle cycles -> abort
      e_edit = 1'b1;
      step("d_enter2", KD, P0);
      for (int j = 0; j < 19; j++) step("idle_e", 8'd0, P0);
      e_edit = 1'b0;
      step("timeout_b", 8'd0, PA);

      // D on the timeout cycle wins
      e_edit = 1'b1;
      step("d_enter3", KD, P0);
      step("rel", 8'd0, P0);
      for (int j = 0; j < 18; j++) step("idle_e", 8'd0, P0);
      e_edit = 1'b0;
      step("d_commit", KD, PC);
      step("rel", 8'd0, P0);

      // chrono controls
      e_mode = 2'd2; step("c_mode", KC, P0); step("rel", 8'd0, P0);
      e_run = 1'b1; step("run1", KU, P0); step("rel", 8'd0, P0);
      e_run = 1'b0; step("run0", KU, P0); step("rel", 8'd0, P0);
      e_run = 1'b1; step("run1b", KU, P0); step("rel", 8'd0, P0);
      e_run = 1'b0; step("clr", KN, PL); step("rel", 8'd0, P0);
      e_run = 1'b1; step("run1c", KU, P0); step("rel", 8'd0, P0);

      // simultaneous edges
      e_mode = 2'd0; step("a_up", KA | KU, P0); step("rel", 8'd0, P0);
      e_edit = 1'b1; e_field = 2'd0; step("d_left", KD | KL, P0); step("rel", 8'd0, P0);
      e_field = 2'd1; step("right_e", KR, P0); step("rel", 8'd0, P0);
      step("a_in_edit", KA, P0); step("rel", 8'd0, P0);

      // reset mid-EDIT with B held through it
      reset = 1'b1;
      e_mode = 2'd0; e_edit = 1'b0; e_field = 2'd0; e_run = 1'b0;
      step("rst_edit", KB, P0);
      step("rst_edit2", KB, P0);
      reset = 1'b0;
      e_mode = 2'd1;
      step("held_b", KB, P0);
      step("rel", 8'd0, P0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_rtc_ctrl.md
# kbd_rtc_ctrl

Command controller between the PS/2 key decoder and the RTC/date/chronometer datapath. It converts the decoder's level-type key flags into single-cycle events, one per cycle. It runs the view/edit state machine for the three display modes (hour, date, chrono) and drives the field cursor. It also issues increment/decrement, commit/abort and chrono run/clear commands, with auto-repeat on held up/down keys.

## Interface
Parameters:
- HOLD_CYC, 50_000_000: cycles up/down must stay held after its first pulse before auto-repeat starts.
- REP_CYC, 10_000_000: auto-repeat period in cycles.
- TIMEOUT_CYC, 1_000_000_000: idle cycles in EDIT before automatic abort.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- key_a, key_b, key_c, key_d, input, 1 each: decoder level flags; high while the key is held.
- key_up, key_down, key_left, key_right, input, 1 each: decoder level flags.
- mode, output, 2: 0 = hour, 1 = date, 2 = chrono (3 is never driven).
- edit, output, 1: high while in EDIT.
- field, output, 2: cursor 0..2 (hh/mm/ss or dd/mm/yy); 0 outside EDIT.
- inc_p, dec_p, output, 1 each: one-cycle increment/decrement of the field at `field`.
- commit_p, abort_p, output, 1 each: one-cycle end-of-edit strobes.
- crono_run, output, 1: chrono running level.
- crono_clr_p, output, 1: one-cycle chrono clear.

## Operation
- Edge detection: one registered copy of each key flag. An event is current = 1 and previous = 0.
- Priority when several edges occur in the same cycle: D > A > B > C > up > down > left > right. Only the winning event is acted on; the others are discarded, not queued.
- VIEW state:
  - A, B, C set mode to 0, 1, 2.
  - D enters EDIT with field = 0.
  - left/right: no effect.
- VIEW, mode = 2:
  - up toggles crono_run.
  - down pulses crono_clr_p and forces crono_run = 0.
- VIEW, mode = 0 or 1: up/down have no effect.
- EDIT state:
  - up → inc_p; down → dec_p.
  - right: field + 1, wrapping 2 → 0. left: field − 1, wrapping 0 → 2.
  - D: commit_p, return to VIEW, field = 0.
  - A, B, C: ignored (mode is frozen in EDIT).
  - crono_run is unchanged by EDIT and keeps its value.
- Auto-repeat (EDIT only, up/down only):
  - Repeat counter clears on every accepted event.
  - While the key that produced the last inc/dec stays high, once the counter reaches HOLD_CYC, pulse again, then every REP_CYC cycles.
  - Releasing the key, or any other key edge, stops repeat.
- Timeout: idle counter in EDIT clears on any accepted event, including repeat pulses. At TIMEOUT_CYC: abort_p, VIEW, field = 0.
- Counter widths: $clog2(max parameter + 1). No wrap is possible.

## Timing
- Reset values: mode = 0, edit = 0, field = 0, all pulse outputs = 0, crono_run = 0, edge and repeat registers = 0, state = VIEW.
- All outputs are registered. A key flag first high at edge k yields its output or state change visible after edge k, i.e. 1-cycle latency.
- Each pulse output is high for exactly one cycle. At most one of inc_p, dec_p, commit_p, abort_p, crono_clr_p is high in any cycle.
- Repeat timing: first pulse at edge k; second at edge k + HOLD_CYC; then every REP_CYC.
- D edge and timeout in the same cycle: D wins (commit_p, not abort_p).
- Key held through reset: after reset deasserts, the previous-value register is 0, so the held key produces an edge on the first cycle.
- Reset in EDIT: returns to VIEW with no commit_p or abort_p.

## Test plan
Run with HOLD_CYC = 4, REP_CYC = 2, TIMEOUT_CYC = 20.
- Reset, then press B for 3 cycles → mode = 1 one cycle after the press; no pulses; releasing B has no effect.
- Press D; press right 3×; press left 1× → edit = 1, field sequence 0 → 1 → 2 → 0 → 2.
- In EDIT, hold up for 12 cycles → inc_p at cycles 0, 4, 6, 8, 10 relative to the first pulse; nothing after release.
- In EDIT, no keys for 20 cycles → abort_p for 1 cycle, edit = 0, field = 0. Repeat the same but press D at idle cycle 19 → commit_p, no abort_p.
- mode = 2 in VIEW: up → crono_run = 1; up → 0; up → 1; down → crono_clr_p pulse and crono_run = 0.
- A and up rise in the same cycle in VIEW → mode = 0 and no up action. D and left in the same cycle → enter EDIT with field = 0. Reset asserted mid-EDIT → all outputs at reset values, no strobes.
